alu_ctrl_unit: RTL

Registered, handshaked ALU control unit for the multicycle MIPS datapath. It replaces the single-cycle combinational ALU decoder and widens ALUControl to a 4-bit field. The widened field adds XOR, NOR, SLTU, the shifts and multiply/divide. Multiply/divide requests hold the unit busy for a parametrised number of cycles. It sits between the main control FSM (upstream, valid/ready) and the ALU/mul-div unit (downstream, valid/ready).

---
 rtl/alu_ctrl_pkg.sv | 52 +++++
 rtl/alu_funct_decode.sv | 52 +++++
 rtl/alu_ctrl_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the registered ALU control unit:
//   - alu_code_e : 4-bit ALUControl operation codes
//   - FUNCT_*    : R-type funct field encodings understood by the decoder
//   - ALUOP_*    : main-control aluop encodings (1x means "decode funct")
//   - state_e    : control FSM states
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_NOR   = 4'b0100,
        ALU_SLTU  = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_MULT  = 4'b1100,
        ALU_MULTU = 4'b1101,
        ALU_DIV   = 4'b1110,
        ALU_DIVU  = 4'b1111
    } alu_code_e;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_VALID = 2'd2
    } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode
//   Purely combinational ALU operation decoder.
//   Ports:
//     i_aluop      : 00 add, 01 subtract, 1x decode i_funct
//     i_funct      : R-type function field
//     o_code       : decoded ALUControl code
//     o_is_muldiv  : operation needs the multicycle mul/div path
//     o_is_div     : mul/div operation is a divide (selects busy length)
//     o_illegal    : unsupported funct; o_code falls back to ADD
module alu_funct_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output alu_code_e  o_code,
    output logic       o_is_muldiv,
    output logic       o_is_div,
    output logic       o_illegal
);

    always_comb begin
        o_code      = ALU_ADD;
        o_is_muldiv = 1'b0;
        o_is_div    = 1'b0;
        o_illegal   = 1'b0;
        if (i_aluop == ALUOP_ADD) begin
            o_code = ALU_ADD;
        end else if (i_aluop == ALUOP_SUB) begin
            o_code = ALU_SUB;
        end else begin
            case (i_funct)
                FUNCT_ADD:   o_code = ALU_ADD;
                FUNCT_SUB:   o_code = ALU_SUB;
                FUNCT_AND:   o_code = ALU_AND;
                FUNCT_OR:    o_code = ALU_OR;
                FUNCT_XOR:   o_code = ALU_XOR;
                FUNCT_NOR:   o_code = ALU_NOR;
                FUNCT_SLT:   o_code = ALU_SLT;
                FUNCT_SLTU:  o_code = ALU_SLTU;
                FUNCT_SLL:   o_code = ALU_SLL;
                FUNCT_SRL:   o_code = ALU_SRL;
                FUNCT_SRA:   o_code = ALU_SRA;
                FUNCT_MULT:  begin o_code = ALU_MULT;  o_is_muldiv = 1'b1; end
                FUNCT_MULTU: begin o_code = ALU_MULTU; o_is_muldiv = 1'b1; end
                FUNCT_DIV:   begin o_code = ALU_DIV;   o_is_muldiv = 1'b1; o_is_div = 1'b1; end
                FUNCT_DIVU:  begin o_code = ALU_DIVU;  o_is_muldiv = 1'b1; o_is_div = 1'b1; end
                default:     begin o_code = ALU_ADD;   o_illegal = 1'b1; end
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit
//   Registered, handshaked ALU control unit for the multicycle datapath.
//   Ports:
//     clk, reset_n          : clock (rising edge), async active-low reset
//     in_valid / in_ready   : upstream request handshake
//     aluop, funct          : request payload
//     out_valid / out_ready : downstream result handshake
//     alu_control           : registered ALU operation (upper bits zero)
//     busy                  : multicycle mul/div operation in progress
//     illegal               : result came from an unsupported funct
//     dbg_state             : current FSM state, for observation only
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both high. The producer holds valid and its payload until the
//   transfer; ready may depend combinationally only on out_ready.
module alu_ctrl_unit
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W      = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              busy,
    output logic              illegal,
    output logic [1:0]        dbg_state
);

    // Counter holds at most max(N)-1.
    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_code;
    logic             r_illegal;

    alu_code_e        w_code;
    logic             w_is_muldiv;
    logic             w_is_div;
    logic             w_illegal;
    logic             w_accept;
    logic [CNT_W-1:0] w_load_cnt;

    alu_funct_decode u_decode (
        .i_aluop     (aluop),
        .i_funct     (funct),
        .o_code      (w_code),
        .o_is_muldiv (w_is_muldiv),
        .o_is_div    (w_is_div),
        .o_illegal   (w_illegal)
    );

    // A new request may enter while idle, or while the current result
    // is leaving in the same cycle (gives 1/cycle throughput).
    assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_VALID) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_load_cnt = w_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    assign out_valid   = (r_state == ST_VALID);
    assign busy        = (r_state == ST_BUSY);
    assign alu_control = CTRL_W'(r_code);
    assign illegal     = r_illegal;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_code    <= 4'b0000;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_VALID: begin
                    if (w_accept) begin
                        r_code    <= w_code;
                        r_illegal <= w_illegal;
                        if (w_is_muldiv) begin
                            r_cnt   <= w_load_cnt;
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_VALID;
                        end
                    end else if (r_state == ST_VALID && out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_VALID;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
